// File: rtl/spi_flash_read_cache.sv
// spi_flash_read_cache
//   Single-byte SPI-flash read engine with a one-entry read cache, placed
//   between the CPU address decoder and a serial flash. A CPU read inside
//   the flash window is answered from the cache on a hit. On a miss it
//   issues a Mode 0 READ (0x03) or FAST_READ (0x0B + dummy byte) and holds
//   the CPU in a wait state until the byte is back.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous, active-low
//   spi_ce         flash window select
//   i_ADDRESS_BUS  CPU address
//   i_RW           1 = read (writes are ignored)
//   i_INVALIDATE   single-cycle pulse, clears the cache valid bit
//   i_SPI_MISO     flash serial data out
//   o_SPI_CLK      SCK, idles low
//   o_SPI_MOSI     command/address/dummy bits, MSB first, 0 when idle
//   o_SPI_CS       active-low flash select
//   o_DATA         read byte to the CPU data mux
//   o_MemoryReady  0 = CPU wait state
module spi_flash_read_cache #(
   parameter int unsigned ADDR_BITS  = 12,
   parameter logic [23:0] FLASH_BASE = 24'h000000,
   parameter int unsigned CLK_DIV    = 1,
   parameter bit          FAST_READ  = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        spi_ce,
   input  logic [15:0] i_ADDRESS_BUS,
   input  logic        i_RW,
   input  logic        i_INVALIDATE,
   input  logic        i_SPI_MISO,
   output logic        o_SPI_CLK,
   output logic        o_SPI_MOSI,
   output logic        o_SPI_CS,
   output logic [7:0]  o_DATA,
   output logic        o_MemoryReady
);

   localparam int unsigned NBITS    = FAST_READ ? 48 : 40;
   localparam logic [7:0]  CMD      = FAST_READ ? 8'h0B : 8'h03;
   localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [5:0]  BIT_LAST = 6'(NBITS - 1);
   localparam logic [15:0] ADDR_MASK = 16'((32'd1 << ADDR_BITS) - 32'd1);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t           state;
   logic [23:0]      fa;
   logic [23:0]      fa_q;
   logic [23:0]      cache_tag;
   logic [7:0]       cache_data;
   logic             cache_vld;
   logic             hit;
   logic [47:0]      tx_sr;     // bits still to send after the one on MOSI
   logic [7:0]       rx_sr;
   logic [5:0]       bit_cnt;
   logic [DIV_W-1:0] div_cnt;

   // 24-bit wrap is implicit in the adder width.
   assign fa  = FLASH_BASE + {8'h00, i_ADDRESS_BUS & ADDR_MASK};
   // An invalidate arriving with the request forces a miss.
   assign hit = cache_vld && (cache_tag == fa) && !i_INVALIDATE;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= S_IDLE;
         fa_q          <= '0;
         cache_tag     <= '0;
         cache_data    <= '0;
         cache_vld     <= 1'b0;
         tx_sr         <= '0;
         rx_sr         <= '0;
         bit_cnt       <= '0;
         div_cnt       <= '0;
         o_SPI_CLK     <= 1'b0;
         o_SPI_MOSI    <= 1'b0;
         o_SPI_CS      <= 1'b1;
         o_DATA        <= 8'h00;
         o_MemoryReady <= 1'b1;
      end else begin
         if (i_INVALIDATE) cache_vld <= 1'b0;
         case (state)
            S_IDLE: begin
               if (spi_ce && i_RW) begin
                  if (hit) begin
                     o_DATA <= cache_data;
                  end else begin
                     state         <= S_SHIFT;
                     fa_q          <= fa;
                     o_SPI_CS      <= 1'b0;
                     o_MemoryReady <= 1'b0;
                     o_SPI_MOSI    <= CMD[7];
                     // Remaining frame: cmd[6:0], FA, then zeros for the
                     // dummy byte (if any) and the data phase.
                     tx_sr         <= {CMD[6:0], fa, 17'h00000};
                     bit_cnt       <= '0;
                     div_cnt       <= '0;
                  end
               end
            end
            S_SHIFT: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= '0;
                  if (!o_SPI_CLK) begin
                     o_SPI_CLK <= 1'b1;
                     rx_sr     <= {rx_sr[6:0], i_SPI_MISO};
                  end else if (bit_cnt == BIT_LAST) begin
                     o_SPI_CLK  <= 1'b0;
                     o_SPI_CS   <= 1'b1;
                     o_SPI_MOSI <= 1'b0;
                     o_DATA     <= rx_sr;
                     cache_tag  <= fa_q;
                     cache_data <= rx_sr;
                     // Fill wins over an invalidate seen during the shift.
                     cache_vld  <= 1'b1;
                     state      <= S_DONE;
                  end else begin
                     o_SPI_CLK  <= 1'b0;
                     o_SPI_MOSI <= tx_sr[47];
                     tx_sr      <= {tx_sr[46:0], 1'b0};
                     bit_cnt    <= bit_cnt + 6'd1;
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            S_DONE: begin
               o_MemoryReady <= 1'b1;
               state         <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/spi_flash_read_cache.md
# spi_flash_read_cache

Parametrised SPI-flash read engine for the 6809 memory map: on a CPU read inside the flash window it issues a SPI Mode 0 READ (0x03) or FAST_READ (0x0B) for one byte and holds the CPU in wait via `o_MemoryReady`. It adds a configurable SPI clock divider, a configurable window width and base offset, and a one-entry read cache with explicit invalidate. It sits between the address decoder (`spi_ce`) and the external serial flash, replacing the fixed 12-bit, full-rate read controller.

## Interface
- `ADDR_BITS`, default 12: number of CPU address bits forwarded into the flash address, legal range 1..16.
- `FLASH_BASE`, default 24'h000000: offset added to the forwarded address.
- `CLK_DIV`, default 1: SCK half-period in `clk` cycles, minimum 1.
- `FAST_READ`, default 0: 0 selects command 0x03 with 40 bits per transaction; 1 selects command 0x0B plus one dummy byte, 48 bits per transaction.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `spi_ce`  in  1  flash window select from the address decoder.
- `i_ADDRESS_BUS`  in  16  CPU address.
- `i_RW`  in  1  1 = read; writes are ignored.
- `i_INVALIDATE`  in  1  single-cycle pulse that clears the cache valid bit.
- `i_SPI_MISO`  in  1  flash serial data out.
- `o_SPI_CLK`  out  1  SCK, idles low.
- `o_SPI_MOSI`  out  1  command, address and dummy bits, MSB first; driven 0 when idle.
- `o_SPI_CS`  out  1  active-low flash select.
- `o_DATA`  out  8  read byte to the CPU data mux.
- `o_MemoryReady`  out  1  0 = CPU wait state.

## Operation
- Flash address: `FA = (FLASH_BASE + zero-extended i_ADDRESS_BUS[ADDR_BITS-1:0]) mod 2^24`.
- Cache: holds a 24-bit tag, an 8-bit data byte and a valid bit. It is filled at the end of every completed transaction.
- States: IDLE, SHIFT, DONE.
- **IDLE, request present** (`spi_ce & i_RW`):
  - Hit (valid and tag == FA): `o_DATA <= cached byte` on the next edge; `o_MemoryReady` stays 1; no SPI activity.
  - Miss: latch FA, go to SHIFT; `o_SPI_CS` goes 0, `o_MemoryReady` goes 0, and `o_SPI_MOSI` presents the first command bit.
- **SHIFT**: N = 40 or 48 bits.
  - Each bit is SCK low for `CLK_DIV` cycles, then SCK high for `CLK_DIV` cycles.
  - MOSI updates only at the edge that drives SCK low, or at SHIFT entry for bit 0.
  - MISO is sampled at the edge that drives SCK high.
  - Only the final 8 sampled bits form the data byte, MSB first.
  - Bit sequence: command[7:0], FA[23:0], then a dummy byte (0x00, FAST_READ only), then 8 data bits.
- **End of last high phase**: SCK goes 0, CS goes 1, `o_DATA` is loaded, the cache is filled (tag = FA, valid = 1), go to DONE.
- **DONE**: `o_MemoryReady` goes 1; return to IDLE.
- Requests are not sampled while in SHIFT or DONE.
- `spi_ce` dropping mid-SHIFT does not abort; the transaction completes and fills the cache.
- `i_RW = 0` with `spi_ce` = 1: no action, ready stays 1.
- `i_INVALIDATE` clears valid. If asserted in the same cycle as an IDLE request, the request is treated as a miss. If asserted during SHIFT, it is ignored for the fill in progress (the fill sets valid).
- Reset (asynchronous, any state):
  - State goes to IDLE and cache valid goes 0.
  - `o_SPI_CS` = 1, `o_SPI_CLK` = 0, `o_SPI_MOSI` = 0, `o_DATA` = 0x00, `o_MemoryReady` = 1.
  - A mid-transaction reset deasserts CS immediately with no completion.

## Timing
- Miss latency: `o_MemoryReady` falls 1 clk after the request edge and rises 2·CLK_DIV·N + 2 clk after it. Example: CLK_DIV = 1, READ gives 82 cycles.
- CS is low for exactly 2·CLK_DIV·N cycles.
- Hit latency: `o_DATA` is valid 1 clk after the request edge. The CPU bus must not sample earlier than that.
- Back-to-back misses: at least one IDLE cycle between transactions, so CS is high for ≥ 2 clk.
- MOSI is stable for a full SCK high phase around each rising edge (Mode 0).

## Test plan
- Reset, then read 0x0123 with CLK_DIV = 1, READ, and the flash model returning 0xA5 -> MOSI carries 0x03, then 0x000123; ready is low for 81 cycles; `o_DATA` = 0xA5; CS is low for 80 cycles.
- Repeat read 0x0123 -> no CS activity, `o_DATA` = 0xA5 after 1 cycle, ready never drops. Pulse `i_INVALIDATE`, then read 0x0123 again -> a full SPI transaction occurs.
- FAST_READ = 1, CLK_DIV = 3, FLASH_BASE = 24'h010000, ADDR_BITS = 16, read 0xFFFF -> MOSI carries 0x0B, then 0x01FFFF, then 0x00; ready rises 290 cycles after the request; SCK high and low phases are each 3 cycles.
- FLASH_BASE = 24'hFFFFF0, read 0x0020 -> address 0x000010 (24-bit wrap).
- Assert reset on bit 20 of a miss -> CS = 1, SCK = 0, ready = 1 asynchronously; the next read of the same address is a miss.
- Drop `spi_ce` mid-SHIFT -> the transaction completes, and a following read of that address hits. A write cycle (`i_RW` = 0) in the window -> no SPI activity.
